// File: rtl/frame_buffer_pingpong_pkg.sv
// Shared definitions for the ping-pong frame store.
//   fb_bank_e : bank index encoding (FB_BANK0 / FB_BANK1)
//   clog2     : ceiling log2, used to size the per-bank RAM address
package fb_pkg;

  typedef enum logic {
    FB_BANK0 = 1'b0,
    FB_BANK1 = 1'b1
  } fb_bank_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/frame_buffer_pingpong_bank_ram.sv
// fb_bank_ram: simple dual-port synchronous RAM, one bank of the frame store.
//   clk_i  : clock
//   we     : write enable, stores wr_dat at wr_adr
//   wr_adr : write address (AW bits)
//   wr_dat : write data (WIDTH bits)
//   re     : read enable, loads rd_dat from rd_adr; rd_dat holds otherwise
//   rd_adr : read address (AW bits)
//   rd_dat : registered read data
// Contents are not reset so the array maps onto block RAM.
module fb_bank_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 307200,
  parameter int unsigned AW    = 19
) (
  input  logic             clk_i,
  input  logic             we,
  input  logic [AW-1:0]    wr_adr,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             re,
  input  logic [AW-1:0]    rd_adr,
  output logic [WIDTH-1:0] rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) mem[wr_adr] <= wr_dat;
    if (re) rd_dat <= mem[rd_adr];
  end

endmodule

// File: rtl/frame_buffer_pingpong.sv
// frame_buffer_pingpong: double-buffered frame store. Capture side fills bank
// wr_bank_o while the reader reads the other bank; banks swap when a frame
// completes (write at DEPTH-1) unless the reader holds rd_lock_i.
//   clk_i, rst          : clock, async active-high reset
//   we_i/wr_adr_i/dat_i : capture-side write port
//   re_i/rd_adr_i       : reader-side read request
//   rd_lock_i           : reader pins its bank; completed frames are dropped
//   dat_o/rd_valid_o    : read data and one-cycle valid pulse
//   frame_rdy_o         : read bank holds a complete frame (sticky)
//   frame_cnt_o         : completed frames accepted (wraps)
//   overrun_o           : sticky, a completed frame was dropped
//   wr_bank_o           : bank currently being written
// Build option FB_OUT_REG_EN: extra output register, read latency 2 instead of 1.
module frame_buffer_pingpong
  import fb_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 307200,
  parameter int unsigned AW    = 19,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    wr_adr_i,
  input  logic [WIDTH-1:0] dat_i,
  input  logic             re_i,
  input  logic [AW-1:0]    rd_adr_i,
  input  logic             rd_lock_i,
  output logic [WIDTH-1:0] dat_o,
  output logic             rd_valid_o,
  output logic             frame_rdy_o,
  output logic [CNT_W-1:0] frame_cnt_o,
  output logic             overrun_o,
  output logic             wr_bank_o
);

  localparam int unsigned   IW       = clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_L  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADR = AW'(DEPTH - 1);

  fb_bank_e         wr_bank;
  logic             wr_accept, wr_last, rd_in_range, rd_accept;
  logic             rd_sel_q, rd_zero_q, rd_valid_q;
  logic [WIDTH-1:0] q0, q1, dat_mux;
  logic             frame_rdy_q, overrun_q;
  logic [CNT_W-1:0] frame_cnt_q;

  assign wr_accept   = we_i && ({1'b0, wr_adr_i} < DEPTH_L);
  assign wr_last     = wr_accept && (wr_adr_i == LAST_ADR);
  assign rd_in_range = ({1'b0, rd_adr_i} < DEPTH_L);
  assign rd_accept   = re_i && rd_in_range;

  fb_bank_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(IW)) u_bank0 (
    .clk_i  (clk_i),
    .we     (wr_accept && (wr_bank == FB_BANK0)),
    .wr_adr (wr_adr_i[IW-1:0]),
    .wr_dat (dat_i),
    .re     (rd_accept && (wr_bank == FB_BANK1)),
    .rd_adr (rd_adr_i[IW-1:0]),
    .rd_dat (q0)
  );

  fb_bank_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(IW)) u_bank1 (
    .clk_i  (clk_i),
    .we     (wr_accept && (wr_bank == FB_BANK1)),
    .wr_adr (wr_adr_i[IW-1:0]),
    .wr_dat (dat_i),
    .re     (rd_accept && (wr_bank == FB_BANK0)),
    .rd_adr (rd_adr_i[IW-1:0]),
    .rd_dat (q1)
  );

  // Bank and range are captured with the request, so a swap on the same edge
  // cannot tear the word. rd_zero_q resets high so dat_o reads 0 before any
  // read without resetting the RAM output registers; since the RAM outputs
  // and these selects only move on re_i, dat_mux holds between reads.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      rd_sel_q   <= 1'b0;
      rd_zero_q  <= 1'b1;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= re_i;
      if (re_i) begin
        rd_sel_q  <= (wr_bank == FB_BANK0);
        rd_zero_q <= ~rd_in_range;
      end
    end
  end

  assign dat_mux = rd_zero_q ? '0 : (rd_sel_q ? q1 : q0);

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      wr_bank     <= FB_BANK0;
      frame_rdy_q <= 1'b0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else if (wr_last) begin
      if (rd_lock_i) begin
        overrun_q <= 1'b1;
      end else begin
        wr_bank     <= (wr_bank == FB_BANK0) ? FB_BANK1 : FB_BANK0;
        frame_rdy_q <= 1'b1;
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  assign frame_rdy_o = frame_rdy_q;
  assign frame_cnt_o = frame_cnt_q;
  assign overrun_o   = overrun_q;
  assign wr_bank_o   = wr_bank;

`ifdef FB_OUT_REG_EN
  logic [WIDTH-1:0] dat_q2;
  logic             rd_valid_q2;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      dat_q2      <= '0;
      rd_valid_q2 <= 1'b0;
    end else begin
      rd_valid_q2 <= rd_valid_q;
      if (rd_valid_q) dat_q2 <= dat_mux;
    end
  end

  assign dat_o      = dat_q2;
  assign rd_valid_o = rd_valid_q2;
`else
  assign dat_o      = dat_mux;
  assign rd_valid_o = rd_valid_q;
`endif

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
module tb_frame_buffer_pingpong;

  localparam int DEPTH = 16;
  localparam int AW    = 5;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
`ifdef FB_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk_i = 1'b0;
  logic             rst;
  logic             we_i, re_i, rd_lock_i;
  logic [AW-1:0]    wr_adr_i, rd_adr_i;
  logic [WIDTH-1:0] dat_i;
  logic [WIDTH-1:0] dat_o;
  logic             rd_valid_o, frame_rdy_o, overrun_o, wr_bank_o;
  logic [CNT_W-1:0] frame_cnt_o;

  always #5 clk_i = ~clk_i;

  frame_buffer_pingpong #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .rst         (rst),
    .we_i        (we_i),
    .wr_adr_i    (wr_adr_i),
    .dat_i       (dat_i),
    .re_i        (re_i),
    .rd_adr_i    (rd_adr_i),
    .rd_lock_i   (rd_lock_i),
    .dat_o       (dat_o),
    .rd_valid_o  (rd_valid_o),
    .frame_rdy_o (frame_rdy_o),
    .frame_cnt_o (frame_cnt_o),
    .overrun_o   (overrun_o),
    .wr_bank_o   (wr_bank_o)
  );

  // Reference model: two word arrays, a bank pointer and a queue of read
  // results in flight; a read result emerges LAT edges after its request.
  typedef struct {
    bit v;
    int d;
    bit k;
  } rd_t;

  int  m_mem   [2][DEPTH];
  bit  m_known [2][DEPTH];
  int  m_wr_bank, m_cnt, m_rdy, m_ovr;
  int  exp_valid, exp_dat;
  bit  exp_known;
  rd_t pipe[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wr_bank = 0;
    m_cnt     = 0;
    m_rdy     = 0;
    m_ovr     = 0;
    pipe.delete();
    exp_valid = 0;
    exp_dat   = 0;
    exp_known = 1'b1;
  endtask

  task automatic model_edge();
    rd_t e, o;
    int  rb;
    int  ra, wa;
    rb  = 1 - m_wr_bank;
    ra  = int'(rd_adr_i);
    wa  = int'(wr_adr_i);
    e.v = re_i;
    e.d = 0;
    e.k = 1'b1;
    if (re_i && ra < DEPTH) begin
      e.d = m_mem[rb][ra];
      e.k = m_known[rb][ra];
    end
    pipe.push_back(e);
    if (pipe.size() >= LAT) begin
      o = pipe.pop_front();
      exp_valid = o.v;
      if (o.v) begin
        exp_dat   = o.d;
        exp_known = o.k;
      end
    end
    if (we_i && wa < DEPTH) begin
      m_mem[m_wr_bank][wa]   = int'(dat_i);
      m_known[m_wr_bank][wa] = 1'b1;
      if (wa == DEPTH - 1) begin
        if (rd_lock_i) m_ovr = 1;
        else begin
          m_wr_bank = 1 - m_wr_bank;
          m_rdy     = 1;
          m_cnt     = (m_cnt + 1) % (1 << CNT_W);
        end
      end
    end
  endtask

  task automatic check_all();
    check("wr_bank", 32'(wr_bank_o), 32'(m_wr_bank));
    check("frame_rdy", 32'(frame_rdy_o), 32'(m_rdy));
    check("frame_cnt", 32'(frame_cnt_o), 32'(m_cnt));
    check("overrun", 32'(overrun_o), 32'(m_ovr));
    check("rd_valid", 32'(rd_valid_o), 32'(exp_valid));
    if (exp_known) check("dat", 32'(dat_o), 32'(exp_dat));
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [WIDTH-1:0] d,
                       input logic re, input logic [AW-1:0] ra, input logic lock);
    we_i      = we;
    wr_adr_i  = wa;
    dat_i     = d;
    re_i      = re;
    rd_adr_i  = ra;
    rd_lock_i = lock;
    @(posedge clk_i);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, rd_lock_i);
  endtask

  task automatic write_frame(input logic [WIDTH-1:0] base, input logic lock, input logic rd);
    for (int a = 0; a < DEPTH; a++)
      drive(1'b1, AW'(a), base + WIDTH'(a), rd, AW'(a), lock);
  endtask

  // Reset asserted between clock edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    #3;
    rst = 1'b1;
    we_i = 1'b0; re_i = 1'b0; rd_lock_i = 1'b0;
    model_reset();
    #1;
    check("rst_wr_bank", 32'(wr_bank_o), 32'd0);
    check("rst_dat", 32'(dat_o), 32'd0);
    check("rst_valid", 32'(rd_valid_o), 32'd0);
    check_all();
    @(posedge clk_i);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int wptr;
    logic we;
    logic [AW-1:0] wa;

    rst = 1'b1;
    we_i = 1'b0; wr_adr_i = '0; dat_i = '0;
    re_i = 1'b0; rd_adr_i = '0; rd_lock_i = 1'b0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < DEPTH; a++) m_known[b][a] = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_all();
    rst = 1'b0;

    // 1: partial frame then reset mid-cycle
    for (int a = 0; a < 5; a++) drive(1'b1, AW'(a), 8'($urandom), 1'b0, '0, 1'b0);
    async_reset();

    // 2: first frame, then read it back
    write_frame(8'h10, 1'b0, 1'b0);
    check("f1_wr_bank", 32'(wr_bank_o), 32'd1);
    check("f1_rdy", 32'(frame_rdy_o), 32'd1);
    check("f1_cnt", 32'(frame_cnt_o), 32'd1);
    for (int a = 0; a < DEPTH; a++) drive(1'b0, '0, '0, 1'b1, AW'(a), 1'b0);
    repeat (LAT) idle();
    check("f1_hold", 32'(dat_o), 32'h1F);
    check("f1_valid_end", 32'(rd_valid_o), 32'd0);

    // 3: locked completion is dropped
    write_frame(8'hA0, 1'b1, 1'b1);
    check("lock_ovr", 32'(overrun_o), 32'd1);
    check("lock_cnt", 32'(frame_cnt_o), 32'd1);
    check("lock_bank", 32'(wr_bank_o), 32'd1);

    // 4: write frame 2 while reading the other bank every cycle
    write_frame(8'h40, 1'b0, 1'b1);
    check("f2_bank", 32'(wr_bank_o), 32'd0);
    check("f2_cnt", 32'(frame_cnt_o), 32'd2);
    check("f2_ovr", 32'(overrun_o), 32'd1);

    // 5: out-of-range addresses
    drive(1'b1, AW'(DEPTH), 8'h55, 1'b0, '0, 1'b0);
    check("oor_wr_bank", 32'(wr_bank_o), 32'd0);
    drive(1'b0, '0, '0, 1'b1, AW'(DEPTH), 1'b0);
    for (int i = 1; i < LAT; i++) idle();
    check("oor_rd_dat", 32'(dat_o), 32'd0);
    check("oor_rd_valid", 32'(rd_valid_o), 32'd1);

    // 5b: counter wrap over 16 frames from reset
    async_reset();
    for (int f = 0; f < 16; f++) write_frame(8'(f * 16), 1'b0, 1'($urandom));
    check("wrap_cnt", 32'(frame_cnt_o), 32'd0);
    check("wrap_bank", 32'(wr_bank_o), 32'd0);
    check("wrap_rdy", 32'(frame_rdy_o), 32'd1);

    // Randomized traffic against the model
    wptr = 0;
    for (int i = 0; i < 600; i++) begin
      we = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) wa = AW'($urandom_range(0, DEPTH + 3));
      else wa = AW'(wptr);
      if (we && int'(wa) == wptr) wptr = (wptr + 1) % DEPTH;
      drive(we, wa, 8'($urandom), 1'($urandom), AW'($urandom_range(0, DEPTH + 3)),
            ($urandom_range(0, 9) < 2));
      if (i == 400) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
